imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//   Instruction-memory responder on the fetch side of the IFU: receives PC fetch addresses over a
//   valid/ready request channel and returns instruction words in order over a valid/ready response
//   channel. Provides a LATENCY-stage read pipeline, a response FIFO for backpressure, range/alignment
//   checking against the code base 0x00003000, a program-load write port and a flush for PC redirects.
// PARAMETERS
//   BASE_ADDR    32'h00003000  byte address of word 0 (code start)
//   DEPTH_WORDS  4096          memory words; legal range BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1
//   LATENCY      2             accept-to-response cycles, legal 1..4
//   FIFO_DEPTH   4             max outstanding requests (pipeline + FIFO), legal >= 1; full rate needs >= LATENCY+1
// PORTS
//   clk        in   1   clock, rising edge
//   RESET_N    in   1   reset, asynchronous, active-low
//   flush      in   1   sync: discard all in-flight and queued responses
//   req_valid  in   1   fetch request valid
//   req_ready  out  1   request accepted this cycle when req_valid && req_ready
//   req_addr   in   32  fetch byte address (PC)
//   rsp_valid  out  1   response valid
//   rsp_ready  in   1   consumer takes response when rsp_valid && rsp_ready
//   rsp_instr  out  32  instruction word (32'h0 on error)
//   rsp_addr   out  32  req_addr of the request this response answers
//   rsp_err    out  1   1 = misaligned or out-of-range address
//   ld_we      in   1   program-load write enable
//   ld_addr    in   32  load byte address (same range/alignment rules)
//   ld_data    in   32  load word
// BEHAVIOUR
//   - Reset (RESET_N=0, async): rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, req_ready=0, pipeline
//     valids and FIFO cleared, outstanding=0. Memory contents NOT reset. req_ready=1 from first edge after release.
//   - Reset asserted mid-operation: all in-flight/queued responses lost, no partial response ever driven.
//   - req_ready = !flush && (outstanding < FIFO_DEPTH); registered-state only, no path from rsp_ready.
//   - outstanding: +1 on request fire, -1 on response fire, unchanged when both in one cycle; 0 on flush.
//   - Address check: err = addr[1:0]!=0 || addr < BASE_ADDR || ((addr-BASE_ADDR)>>2) >= DEPTH_WORDS.
//     Error request still occupies a slot and answers in order with rsp_instr=0, rsp_err=1.
//   - Memory read at accept edge E; entry travels LATENCY-1 further registered stages; rsp_valid first
//     high after edge E+LATENCY when FIFO empty and consumer ready. Otherwise queued in FIFO.
//   - Strict in-order responses; rsp_* held stable while rsp_valid && !rsp_ready.
//   - Back-to-back: with FIFO_DEPTH >= LATENCY+1 and rsp_ready=1, one request and one response per cycle.
//   - FIFO full: cannot overflow, req_ready deasserts at outstanding==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
//   - flush: at the edge, all pipeline valids and FIFO entries dropped, rsp_valid=0 next cycle; request
//     presented in the flush cycle is NOT accepted; response shown in flush cycle counts as delivered
//     only if rsp_ready=1 that cycle.
//   - Load port: ld_we writes ld_data at edge; illegal ld_addr ignored silently. Fetch of same word in
//     same cycle returns OLD contents; following cycles see new data.
//   - flush and reset have no effect on memory contents.
// TESTING
//   1. Reset release, load 0x3000<=32'h2408_0001, fetch 0x3000, rsp_ready=1 -> rsp_valid 2 cycles after
//      accept, rsp_instr=32'h2408_0001, rsp_addr=0x3000, rsp_err=0.
//   2. Stream 0x3000,0x3004,...,0x301C with rsp_ready=1 -> 8 responses in order, one per cycle, req_ready constant 1.
//   3. rsp_ready=0, issue 6 requests -> exactly 4 accepted, req_ready=0 thereafter, rsp_* stable; raise
//      rsp_ready -> 4 responses in order, req_ready returns 1 after first response fire.
//   4. Fetch 0x3002, 0x2FFC, 0x3000+4*4096 -> three responses rsp_err=1, rsp_instr=0; valid fetch after is correct.
//   5. 3 requests outstanding, pulse flush -> rsp_valid=0 next cycle, no stale response ever appears,
//      req_ready=0 in flush cycle; new fetch 0x3010 answers with its own data.
//   6. Same-cycle ld_we to 0x3008 and fetch 0x3008 -> old word returned; refetch returns new word;
//      assert RESET_N low with 2 in flight -> rsp_valid=0 immediately, memory word persists after reset.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: in-order valid/ready fetch responses from a word memory
// with a fixed-latency read pipeline, a backpressure FIFO, address checking and a load port.
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] instr;
  } rsp_t;

  function automatic logic addr_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2) >= DEPTH_WORDS);
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [31:0] a);
    return IdxW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [31:0]         mem_q [DEPTH_WORDS];
  logic                init_q;
  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic [LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
  rsp_t                pipe_q [LATENCY];
  rsp_t                pipe_d [LATENCY];
  rsp_t                fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic        req_fire, rsp_fire, push, pop, rd_err, ld_ok;
  logic [31:0] rd_word;
  rsp_t        head;

  // Memory contents deliberately have no reset; the read below sees pre-write data.
  assign ld_ok = ld_we && !addr_err(ld_addr);

  always_ff @(posedge clk) begin
    if (ld_ok) mem_q[addr_idx(ld_addr)] <= ld_data;
  end

  assign rd_err  = addr_err(req_addr);
  assign rd_word = rd_err ? 32'h0 : mem_q[addr_idx(req_addr)];

  // init_q holds req_ready low until the first edge after reset release.
  assign req_ready = init_q && !flush && (outstanding_q < CntW'(FIFO_DEPTH));
  assign req_fire  = req_valid && req_ready;

  assign head      = fifo_q[rptr_q];
  assign rsp_valid = (cnt_q != '0);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_instr = rsp_valid ? head.instr : 32'h0;
  assign rsp_addr  = rsp_valid ? head.addr : 32'h0;
  assign rsp_err   = rsp_valid && head.err;

  always_comb begin
    pipe_vld_d    = '0;
    pipe_d[0]     = '{err: rd_err, addr: req_addr, instr: rd_word};
    pipe_vld_d[0] = req_fire;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_d[k]     = pipe_q[k-1];
    end
    if (flush) pipe_vld_d = '0;
  end

  // Outstanding never exceeds FIFO_DEPTH, so a push always finds a free FIFO slot.
  assign push = pipe_vld_q[LATENCY-1] && !flush;
  assign pop  = rsp_fire && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (flush) begin
      outstanding_d = '0;
    end else begin
      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding_d = outstanding_q + CntW'(1);
        2'b01:   outstanding_d = outstanding_q - CntW'(1);
        default: outstanding_d = outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= pipe_q[LATENCY-1];
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      init_q        <= 1'b0;
      outstanding_q <= '0;
      pipe_vld_q    <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      init_q        <= 1'b1;
      outstanding_q <= outstanding_d;
      pipe_vld_q    <= pipe_vld_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      for (int k = 0; k < LATENCY; k++) pipe_q[k] <= pipe_d[k];
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder (default parameters).
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        RESET_N, flush, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_we;
  logic [31:0] req_addr, rsp_instr, rsp_addr, ld_addr, ld_data;

  int total = 0;
  int bad   = 0;
  int acc;

  logic [31:0] s_addr  [8];
  logic [31:0] s_instr [8];
  logic        s_err   [8];

  imem_fetch_responder dut (
    .clk       (clk),
    .RESET_N   (RESET_N),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wv(input int i);
    return (i == 0) ? 32'h2408_0001 : (32'hA000_0000 | 32'(i));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Back-to-back requests with rsp_ready=1; response i shows 3 iterations after it is driven.
  task automatic run_stream(input int n);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) begin
        req_valid = 1'b1;
        req_addr  = s_addr[i];
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (i < n) chk("stream_ready", {31'b0, req_ready}, 32'd1);
      if (i >= 3) begin
        chk("stream_valid", {31'b0, rsp_valid}, 32'd1);
        chk("stream_addr", rsp_addr, s_addr[i-3]);
        chk("stream_instr", rsp_instr, s_instr[i-3]);
        chk("stream_err", {31'b0, rsp_err}, {31'b0, s_err[i-3]});
      end
      cyc();
    end
    chk("stream_drained", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    #1 RESET_N = 1'b0;
    #11;
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_instr", rsp_instr, 32'h0);
    chk("rst_addr", rsp_addr, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    repeat (2) cyc();
    RESET_N = 1'b1;
    #1 chk("rel_ready_before_edge", {31'b0, req_ready}, 32'd0);
    cyc();
    chk("rel_ready", {31'b0, req_ready}, 32'd1);

    // Program load, plus two illegal writes that would alias word 0 if not rejected.
    for (int i = 0; i < 8; i++) begin
      ld_we = 1'b1; ld_addr = 32'h3000 + 32'(4 * i); ld_data = wv(i);
      cyc();
    end
    ld_addr = 32'h3002; ld_data = 32'hFFFF_FFFF; cyc();
    ld_addr = 32'h7000; ld_data = 32'hEEEE_EEEE; cyc();
    ld_we = 1'b0;

    // Single fetch latency
    req_valid = 1'b1; req_addr = 32'h3000; rsp_ready = 1'b1;
    #1 chk("t1_ready", {31'b0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
    chk("t1_valid_e1", {31'b0, rsp_valid}, 32'd0);
    cyc();
    chk("t1_valid_e2", {31'b0, rsp_valid}, 32'd0);
    cyc();
    chk("t1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t1_instr", rsp_instr, 32'h2408_0001);
    chk("t1_addr", rsp_addr, 32'h3000);
    chk("t1_err", {31'b0, rsp_err}, 32'd0);
    cyc();
    chk("t1_done", {31'b0, rsp_valid}, 32'd0);

    // Full-rate stream
    for (int i = 0; i < 8; i++) begin
      s_addr[i] = 32'h3000 + 32'(4 * i); s_instr[i] = wv(i); s_err[i] = 1'b0;
    end
    run_stream(8);

    // Backpressure fills to FIFO_DEPTH
    rsp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_addr = 32'h3000 + 32'(4 * i);
      #1;
      chk("t3_ready", {31'b0, req_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (req_valid && req_ready) acc++;
      cyc();
    end
    req_valid = 1'b0;
    cyc(); cyc();
    chk("t3_accepted", 32'(acc), 32'd4);
    chk("t3_full_ready", {31'b0, req_ready}, 32'd0);
    chk("t3_hold_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t3_hold_addr", rsp_addr, 32'h3000);
    chk("t3_hold_instr", rsp_instr, wv(0));
    cyc();
    chk("t3_stable_addr", rsp_addr, 32'h3000);
    chk("t3_stable_instr", rsp_instr, wv(0));
    rsp_ready = 1'b1;
    #1 chk("t3_no_comb_ready", {31'b0, req_ready}, 32'd0);
    cyc();
    chk("t3_ready_back", {31'b0, req_ready}, 32'd1);
    chk("t3_r1_addr", rsp_addr, 32'h3004);
    chk("t3_r1_instr", rsp_instr, wv(1));
    cyc();
    chk("t3_r2_addr", rsp_addr, 32'h3008);
    cyc();
    chk("t3_r3_addr", rsp_addr, 32'h300C);
    chk("t3_r3_instr", rsp_instr, wv(3));
    cyc();
    chk("t3_drained", {31'b0, rsp_valid}, 32'd0);

    // Error addresses, then a legal fetch
    s_addr[0] = 32'h3002; s_addr[1] = 32'h2FFC; s_addr[2] = 32'h7000; s_addr[3] = 32'h3004;
    for (int i = 0; i < 3; i++) begin
      s_instr[i] = 32'h0; s_err[i] = 1'b1;
    end
    s_instr[3] = wv(1); s_err[3] = 1'b0;
    run_stream(4);

    // Flush with three outstanding
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'h3000 + 32'(4 * i);
      cyc();
    end
    req_addr = 32'h300C; flush = 1'b1;
    #1;
    chk("t5_flush_ready", {31'b0, req_ready}, 32'd0);
    chk("t5_pre_valid", {31'b0, rsp_valid}, 32'd1);
    cyc();
    flush = 1'b0; req_valid = 1'b0;
    chk("t5_post_valid", {31'b0, rsp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_no_stale", {31'b0, rsp_valid}, 32'd0);
    end
    chk("t5_ready", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h3010;
    cyc();
    req_valid = 1'b0;
    cyc(); cyc();
    chk("t5_new_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t5_new_addr", rsp_addr, 32'h3010);
    chk("t5_new_instr", rsp_instr, wv(4));
    cyc();
    chk("t5_done", {31'b0, rsp_valid}, 32'd0);

    // Same-cycle load and fetch
    ld_we = 1'b1; ld_addr = 32'h3008; ld_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 32'h3008;
    cyc();
    ld_we = 1'b0; req_valid = 1'b0;
    cyc(); cyc();
    chk("t6_old_instr", rsp_instr, wv(2));
    cyc();
    req_valid = 1'b1; req_addr = 32'h3008;
    cyc();
    req_valid = 1'b0;
    cyc(); cyc();
    chk("t6_new_instr", rsp_instr, 32'hDEAD_BEEF);
    cyc();

    // Asynchronous reset with two in flight
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h3000; cyc();
    req_addr = 32'h3004; cyc();
    req_valid = 1'b0;
    cyc();
    chk("t6_pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t6_rst_ready", {31'b0, req_ready}, 32'd0);
    chk("t6_rst_instr", rsp_instr, 32'h0);
    chk("t6_rst_addr", rsp_addr, 32'h0);
    cyc(); cyc();
    RESET_N = 1'b1;
    cyc();
    chk("t6_rel_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t6_rel_ready", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h3008;
    cyc();
    req_valid = 1'b0;
    cyc(); cyc();
    chk("t6_persist_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t6_persist_instr", rsp_instr, 32'hDEAD_BEEF);
    cyc();
    chk("t6_done", {31'b0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
